// File: rtl/mcpu_ctrl.sv
// +----------------------------------------------------------------------------+
// | mcpu_ctrl : multi-cycle MIPS-subset control FSM with memory watchdog       |
// | Revision  : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module mcpu_ctrl #(
    parameter int CNT_W    = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       INSTop,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             Link,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOpSel,
    output logic [1:0]       PCSrc,
    output logic [1:0]       EXTOp,
    output logic [2:0]       state,
    output logic             fault,
    output logic [CNT_W-1:0] cycles,
    output logic [CNT_W-1:0] instret
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEMACC = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                retire;
    logic [CNT_W-1:0]    cycles_q, instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            wait_q    <= '0;
            cycles_q  <= '0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q != S_FAULT)
                cycles_q <= cycles_q + CNT_W'(1);
            if (retire)
                instret_q <= instret_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        wait_d   = '0;
        retire   = 1'b0;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        Link     = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'd0;
        ALUOpSel = 2'd0;
        PCSrc    = 2'd0;
        EXTOp    = 2'd0;
        fault    = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_W'(WAIT_MAX)) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            S_DECODE: begin
                ALUSrcB = 2'd3;
                case (INSTop)
                    OP_J, OP_JAL: begin
                        PCWrite  = 1'b1;
                        PCSrc    = 2'd2;
                        RegWrite = (INSTop == OP_JAL);
                        Link     = (INSTop == OP_JAL);
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            PCWrite = 1'b1;
                            PCSrc   = 2'd3;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_EXEC;
                        end
                    end
                    OP_LW, OP_SW, OP_BEQ, OP_BNE,
                    OP_ADDI, OP_ORI, OP_LUI: state_d = S_EXEC;
                    default:                 state_d = S_FAULT;
                endcase
            end

            S_EXEC: begin
                ALUSrcA = 1'b1;
                case (INSTop)
                    OP_RTYPE: begin
                        ALUOpSel = 2'd2;
                        state_d  = S_WB;
                    end
                    OP_ADDI, OP_ORI, OP_LUI: begin
                        ALUSrcB  = 2'd2;
                        ALUOpSel = 2'd3;
                        EXTOp    = (INSTop == OP_ADDI) ? 2'd1 :
                                   (INSTop == OP_ORI)  ? 2'd0 : 2'd2;
                        state_d  = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        ALUSrcB = 2'd2;
                        EXTOp   = 2'd1;
                        state_d = S_MEMACC;
                    end
                    OP_BEQ, OP_BNE: begin
                        ALUOpSel = 2'd1;
                        PCSrc    = 2'd1;
                        PCWrite  = (INSTop == OP_BEQ) ? zero : ~zero;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    default: state_d = S_FAULT;
                endcase
            end

            // Only lw/sw reach this state, so anything other than lw is a store.
            S_MEMACC: begin
                IorD     = 1'b1;
                MemRead  = (INSTop == OP_LW);
                MemWrite = (INSTop != OP_LW);
                if (mem_ready) begin
                    if (INSTop == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (wait_q == WAIT_W'(WAIT_MAX)) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = (INSTop == OP_RTYPE);
                MemtoReg = (INSTop == OP_LW);
                retire   = 1'b1;
                state_d  = S_FETCH;
            end

            S_FAULT: fault = 1'b1;

            default: state_d = S_FAULT;
        endcase
    end

    assign state   = state_q;
    assign cycles  = cycles_q;
    assign instret = instret_q;

endmodule

`default_nettype wire

// File: tb/tb_mcpu_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_mcpu_ctrl : table-driven and scoreboard bench for mcpu_ctrl             |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mcpu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  INSTop;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;

    logic        PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst, MemtoReg, Link;
    logic        ALUSrcA, fault;
    logic [1:0]  ALUSrcB, ALUOpSel, PCSrc, EXTOp;
    logic [2:0]  state;
    logic [31:0] cycles, instret;

    logic        w_PCWrite, w_IRWrite, w_MemRead, w_MemWrite, w_IorD, w_RegWrite, w_RegDst;
    logic        w_MemtoReg, w_Link, w_ALUSrcA, w_fault;
    logic [1:0]  w_ALUSrcB, w_ALUOpSel, w_PCSrc, w_EXTOp;
    logic [2:0]  w_state;
    logic [3:0]  w_cycles, w_instret;

    always #5 clk = ~clk;

    mcpu_ctrl #(.CNT_W(32), .WAIT_MAX(4)) dut (
        .clk(clk), .rst(rst), .INSTop(INSTop), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .Link(Link), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOpSel(ALUOpSel), .PCSrc(PCSrc), .EXTOp(EXTOp), .state(state),
        .fault(fault), .cycles(cycles), .instret(instret)
    );

    mcpu_ctrl #(.CNT_W(4), .WAIT_MAX(15)) dut_w (
        .clk(clk), .rst(rst), .INSTop(INSTop), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(w_PCWrite), .IRWrite(w_IRWrite), .MemRead(w_MemRead), .MemWrite(w_MemWrite),
        .IorD(w_IorD), .RegWrite(w_RegWrite), .RegDst(w_RegDst), .MemtoReg(w_MemtoReg),
        .Link(w_Link), .ALUSrcA(w_ALUSrcA), .ALUSrcB(w_ALUSrcB), .ALUOpSel(w_ALUOpSel),
        .PCSrc(w_PCSrc), .EXTOp(w_EXTOp), .state(w_state), .fault(w_fault),
        .cycles(w_cycles), .instret(w_instret)
    );

    // Observed control words grouped by the state in which they matter.
    logic [8:0] act_fetch;
    logic [6:0] act_dec;
    logic [9:0] act_exe;
    logic [2:0] act_mem;
    logic [2:0] act_wb;
    assign act_fetch = {MemRead, IorD, ALUSrcA, ALUSrcB, PCSrc, IRWrite, PCWrite};
    assign act_dec   = {PCWrite, PCSrc, RegWrite, Link, ALUSrcB};
    assign act_exe   = {ALUSrcA, ALUSrcB, ALUOpSel, EXTOp, PCSrc, PCWrite};
    assign act_mem   = {MemRead, MemWrite, IorD};
    assign act_wb    = {RegWrite, RegDst, MemtoReg};

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         lat;
        logic [6:0] dec;
        logic [9:0] exe;
        logic [2:0] mem;
        logic [2:0] wb;
    } vec_t;

    typedef struct {
        int          lat;
        logic [31:0] ret;
    } sb_t;

    vec_t vecs[13];
    sb_t  sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic run_row(input vec_t v);
        sb_t e;
        int  n;
        INSTop    = v.op;
        funct     = v.fn;
        zero      = v.z;
        mem_ready = 1'b1;
        chk({v.name, " fetch"}, {state, act_fetch}, {3'd0, 9'b1_0_0_01_00_1_1});
        sb.push_back('{lat: v.lat, ret: instret + 32'd1});
        n = 0;
        do begin
            step();
            n++;
            case (state)
                3'd1: chk({v.name, " decode"}, act_dec, v.dec);
                3'd2: chk({v.name, " exec"},   act_exe, v.exe);
                3'd3: chk({v.name, " memacc"}, act_mem, v.mem);
                3'd4: chk({v.name, " wb"},     act_wb,  v.wb);
                default: ;
            endcase
        end while (state != 3'd0 && state != 3'd7 && n < 40);
        e = sb.pop_front();
        chk({v.name, " latency"}, n, e.lat);
        chk({v.name, " instret"}, instret, e.ret);
    endtask

    initial begin
        //                name     op          fn          z     lat  dec           exe                  mem     wb
        vecs[0]  = '{"addi",  6'b001000, 6'b000000, 1'b0, 4, 7'b0_00_0_0_11, 10'b1_10_11_01_00_0, 3'b000, 3'b100};
        vecs[1]  = '{"lw",    6'b100011, 6'b000000, 1'b0, 5, 7'b0_00_0_0_11, 10'b1_10_00_01_00_0, 3'b101, 3'b101};
        vecs[2]  = '{"sw",    6'b101011, 6'b000000, 1'b0, 4, 7'b0_00_0_0_11, 10'b1_10_00_01_00_0, 3'b011, 3'b000};
        vecs[3]  = '{"beq_t", 6'b000100, 6'b000000, 1'b1, 3, 7'b0_00_0_0_11, 10'b1_00_01_00_01_1, 3'b000, 3'b000};
        vecs[4]  = '{"j",     6'b000010, 6'b000000, 1'b0, 2, 7'b1_10_0_0_11, 10'b0,               3'b000, 3'b000};
        vecs[5]  = '{"bne_z1",6'b000101, 6'b000000, 1'b1, 3, 7'b0_00_0_0_11, 10'b1_00_01_00_01_0, 3'b000, 3'b000};
        vecs[6]  = '{"bne_z0",6'b000101, 6'b000000, 1'b0, 3, 7'b0_00_0_0_11, 10'b1_00_01_00_01_1, 3'b000, 3'b000};
        vecs[7]  = '{"radd",  6'b000000, 6'b100000, 1'b0, 4, 7'b0_00_0_0_11, 10'b1_00_10_00_00_0, 3'b000, 3'b110};
        vecs[8]  = '{"ori",   6'b001101, 6'b000000, 1'b0, 4, 7'b0_00_0_0_11, 10'b1_10_11_00_00_0, 3'b000, 3'b100};
        vecs[9]  = '{"lui",   6'b001111, 6'b000000, 1'b0, 4, 7'b0_00_0_0_11, 10'b1_10_11_10_00_0, 3'b000, 3'b100};
        vecs[10] = '{"jal",   6'b000011, 6'b000000, 1'b0, 2, 7'b1_10_1_1_11, 10'b0,               3'b000, 3'b000};
        vecs[11] = '{"jr",    6'b000000, 6'b001000, 1'b0, 2, 7'b1_11_0_0_11, 10'b0,               3'b000, 3'b000};
        vecs[12] = '{"beq_nt",6'b000100, 6'b000000, 1'b0, 3, 7'b0_00_0_0_11, 10'b1_00_01_00_01_0, 3'b000, 3'b000};

        INSTop = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;

        do_reset();
        chk("reset state", state, 3'd0);
        chk("reset ctrl", {MemRead, ALUSrcB, fault}, {1'b1, 2'd1, 1'b0});
        chk("reset cycles", cycles, 32'd0);
        chk("reset instret", instret, 32'd0);

        // Mixed program: addi, lw, sw, beq taken, j.
        for (int i = 0; i < 5; i++) run_row(vecs[i]);
        chk("program cycles", cycles, 32'd18);
        chk("program instret", instret, 32'd5);

        for (int i = 5; i < 13; i++) run_row(vecs[i]);

        // lw with three not-ready cycles in MEMACC.
        do_reset();
        INSTop = 6'b100011; funct = 6'b0; mem_ready = 1'b1;
        repeat (3) step();
        chk("stall reach memacc", state, 3'd3);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stall hold %0d", i), {state, MemRead, IorD}, {3'd3, 1'b1, 1'b1});
            step();
        end
        chk("stall hold end", {state, MemRead, IorD}, {3'd3, 1'b1, 1'b1});
        mem_ready = 1'b1;
        step();
        step();
        chk("stall done state", {state, fault}, {3'd0, 1'b0});
        chk("stall cycles", cycles, 32'd8);
        chk("stall instret", instret, 32'd1);

        // Watchdog: sustained FETCH stall faults on the fifth edge.
        do_reset();
        INSTop = 6'b000010; mem_ready = 1'b0;
        repeat (4) step();
        chk("wd pre fault", {state, fault}, {3'd0, 1'b0});
        chk("wd pre cycles", cycles, 32'd4);
        step();
        chk("wd fault", {state, fault}, {3'd7, 1'b1});
        chk("wd fault strobes", {MemRead, IRWrite, PCWrite, ALUSrcB}, 5'b0);
        chk("wd fault cycles", cycles, 32'd5);
        mem_ready = 1'b1;
        repeat (3) step();
        chk("wd sticky", {state, fault}, {3'd7, 1'b1});
        chk("wd frozen cycles", cycles, 32'd5);
        chk("wd instret", instret, 32'd0);

        // Ready arriving when the wait counter sits at WAIT_MAX wins.
        do_reset();
        mem_ready = 1'b0;
        repeat (4) step();
        mem_ready = 1'b1;
        step();
        chk("wd rescue", {state, fault}, {3'd1, 1'b0});
        step();
        chk("wd rescue retire", {state, instret}, {3'd0, 32'd1});

        // Illegal opcode.
        do_reset();
        INSTop = 6'b111111; mem_ready = 1'b1;
        step();
        step();
        chk("illegal fault", {state, fault}, {3'd7, 1'b1});
        chk("illegal instret", instret, 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("illegal recover", {state, fault, MemRead}, {3'd0, 1'b0, 1'b1});
        chk("illegal recover cycles", cycles, 32'd0);

        // Abort mid-instruction: no retire.
        INSTop = 6'b100011;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort", {state, instret}, {3'd0, 32'd0});

        // Counter wrap on the CNT_W=4 instance.
        do_reset();
        for (int i = 0; i < 15; i++) run_row(vecs[4]);
        chk("wrap pre", w_instret, 4'd15);
        run_row(vecs[4]);
        chk("wrap instret", w_instret, 4'd0);
        chk("wrap cycles", w_cycles, 4'd0);
        chk("wrap main instret", instret, 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
